pref_ar_arbiter: RTL and testbench

//  Shares one AXI read port toward DDR between NUM_SLICES prefetcher slices.

---
 rtl/pref_arb_pkg.sv | 22 ++
 rtl/pref_ar_arbiter_rr_pick.sv | 29 ++
 rtl/pref_ar_arbiter.sv | 179 +++++++++++++++++
 tb/tb_pref_ar_arbiter.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/pref_arb_pkg.sv
// Shared types and helpers for the prefetcher AR arbiter.
package pref_arb_pkg;

    localparam int AR_ADDR_W = 64;
    localparam int AR_LEN_W  = 8;
    localparam int AR_TID_W  = 8;

    // R beats whose prefix names no slice are accepted and dropped.
    localparam logic R_SINK_READY = 1'b1;

    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    typedef struct packed {
        logic [AR_ADDR_W-1:0] addr;
        logic [AR_LEN_W-1:0]  len;
        logic [AR_TID_W-1:0]  id;
        logic                 pref;
    } ar_req_t;

endpackage

// File: rtl/pref_ar_arbiter_rr_pick.sv
// Round-robin picker: first set request at or after ptr_i, wrapping at N.
module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] idx_o
);

    int j;

    // Walk offsets from far to near so the nearest request overwrites the rest.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        j     = 0;
        for (int k = N - 1; k >= 0; k--) begin
            j = (int'(ptr_i) + k) % N;
            if (req_i[j]) begin
                gnt_o    = '0;
                gnt_o[j] = 1'b1;
                idx_o    = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/pref_ar_arbiter.sv
// Shares one AXI read port between prefetcher slices: demand-over-prefetch RR
// arbitration, per-slice outstanding limit, R routing by ID prefix.
// PREF_AR_STARVE_GUARD_EN promotes long-waiting prefetch requests to demand.
module pref_ar_arbiter
    import pref_arb_pkg::*;
#(
    parameter int NUM_SLICES      = 4,
    parameter int ADDR_BITS       = 64,
    parameter int BURST_LEN_WIDTH = 8,
    parameter int TID_WIDTH       = 8,
    parameter int DATA_WIDTH      = 64,
    parameter int MAX_OUTST       = 4,
    parameter int STARVE_LIMIT    = 16
) (
    input  logic                                           clk,
    input  logic                                           resetN,
    input  logic [NUM_SLICES-1:0]                          s_ar_valid_i,
    output logic [NUM_SLICES-1:0]                          s_ar_ready_o,
    input  logic [NUM_SLICES-1:0]                          s_ar_pref_i,
    input  logic [NUM_SLICES-1:0][ADDR_BITS-1:0]           s_ar_addr_i,
    input  logic [NUM_SLICES-1:0][BURST_LEN_WIDTH-1:0]     s_ar_len_i,
    input  logic [NUM_SLICES-1:0][TID_WIDTH-1:0]           s_ar_id_i,
    output logic                                           m_ar_valid_o,
    input  logic                                           m_ar_ready_i,
    output logic [ADDR_BITS-1:0]                           m_ar_addr_o,
    output logic [BURST_LEN_WIDTH-1:0]                     m_ar_len_o,
    output logic [idx_w(NUM_SLICES)+TID_WIDTH-1:0]         m_ar_id_o,
    input  logic                                           m_r_valid_i,
    output logic                                           m_r_ready_o,
    input  logic [idx_w(NUM_SLICES)+TID_WIDTH-1:0]         m_r_id_i,
    input  logic                                           m_r_last_i,
    input  logic [DATA_WIDTH-1:0]                          m_r_data_i,
    output logic [NUM_SLICES-1:0]                          s_r_valid_o,
    input  logic [NUM_SLICES-1:0]                          s_r_ready_i,
    output logic [TID_WIDTH-1:0]                           s_r_id_o,
    output logic                                           s_r_last_o,
    output logic [DATA_WIDTH-1:0]                          s_r_data_o
);

    localparam int IDX_W = idx_w(NUM_SLICES);
    localparam int ID_W  = IDX_W + TID_WIDTH;
    localparam int CNT_W = $clog2(MAX_OUTST + 1);

    ar_req_t                 req [NUM_SLICES];
    logic [CNT_W-1:0]        outst_q [NUM_SLICES];
    logic [NUM_SLICES-1:0]   elig, starving, dem_req, pref_req;
    logic [NUM_SLICES-1:0]   dem_gnt, pref_gnt, gnt, r_dec, dec_ok;
    logic [IDX_W-1:0]        dem_idx, pref_idx, win, rr_q, rr_d, r_idx;
    logic                    slot_free, any_dem;
    logic                    m_ar_valid_q;
    logic [ADDR_BITS-1:0]    m_ar_addr_q;
    logic [BURST_LEN_WIDTH-1:0] m_ar_len_q;
    logic [ID_W-1:0]         m_ar_id_q;

    always_comb begin
        for (int i = 0; i < NUM_SLICES; i++) begin
            req[i].addr = AR_ADDR_W'(s_ar_addr_i[i]);
            req[i].len  = AR_LEN_W'(s_ar_len_i[i]);
            req[i].id   = AR_TID_W'(s_ar_id_i[i]);
            req[i].pref = s_ar_pref_i[i];
            elig[i]     = s_ar_valid_i[i] & (outst_q[i] != CNT_W'(MAX_OUTST));
            dem_req[i]  = elig[i] & (~req[i].pref | starving[i]);
            pref_req[i] = elig[i] & req[i].pref;
        end
    end

`ifdef PREF_AR_STARVE_GUARD_EN
    localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);
    logic [WAIT_W-1:0] wait_q [NUM_SLICES];

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < NUM_SLICES; i++) wait_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_SLICES; i++) begin
                if (!s_ar_valid_i[i] || gnt[i])
                    wait_q[i] <= '0;
                else if (elig[i] && s_ar_pref_i[i] && wait_q[i] != WAIT_W'(STARVE_LIMIT))
                    wait_q[i] <= wait_q[i] + WAIT_W'(1);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_SLICES; i++)
            starving[i] = (wait_q[i] == WAIT_W'(STARVE_LIMIT));
    end
`else
    logic [31:0] unused_starve_limit;
    assign unused_starve_limit = 32'(STARVE_LIMIT);
    assign starving = '0;
`endif

    rr_pick #(.N(NUM_SLICES), .IDX_W(IDX_W)) u_dem (
        .req_i(dem_req), .ptr_i(rr_q), .gnt_o(dem_gnt), .idx_o(dem_idx));
    rr_pick #(.N(NUM_SLICES), .IDX_W(IDX_W)) u_pref (
        .req_i(pref_req), .ptr_i(rr_q), .gnt_o(pref_gnt), .idx_o(pref_idx));

    assign any_dem      = |dem_req;
    assign slot_free    = !m_ar_valid_q | m_ar_ready_i;
    assign gnt          = slot_free ? (any_dem ? dem_gnt : pref_gnt) : '0;
    assign win          = any_dem ? dem_idx : pref_idx;
    assign s_ar_ready_o = gnt;

    always_comb begin
        rr_d = rr_q;
        if (|gnt)
            rr_d = (int'(win) == NUM_SLICES - 1) ? '0 : win + IDX_W'(1);
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            m_ar_valid_q <= 1'b0;
            m_ar_addr_q  <= '0;
            m_ar_len_q   <= '0;
            m_ar_id_q    <= '0;
            rr_q         <= '0;
        end else begin
            rr_q <= rr_d;
            if (|gnt) begin
                m_ar_valid_q <= 1'b1;
                m_ar_addr_q  <= ADDR_BITS'(req[win].addr);
                m_ar_len_q   <= BURST_LEN_WIDTH'(req[win].len);
                m_ar_id_q    <= {win, TID_WIDTH'(req[win].id)};
            end else begin
                m_ar_valid_q <= m_ar_valid_q & !m_ar_ready_i;
            end
        end
    end

    assign m_ar_valid_o = m_ar_valid_q;
    assign m_ar_addr_o  = m_ar_addr_q;
    assign m_ar_len_o   = m_ar_len_q;
    assign m_ar_id_o    = m_ar_id_q;

    assign r_idx = m_r_id_i[ID_W-1 -: IDX_W];

    always_comb begin
        s_r_valid_o = '0;
        m_r_ready_o = R_SINK_READY;
        r_dec       = '0;
        for (int i = 0; i < NUM_SLICES; i++) begin
            if (r_idx == IDX_W'(i)) begin
                s_r_valid_o[i] = m_r_valid_i;
                m_r_ready_o    = s_r_ready_i[i];
                r_dec[i]       = m_r_valid_i & s_r_ready_i[i] & m_r_last_i;
            end
        end
    end

    assign s_r_id_o   = m_r_id_i[TID_WIDTH-1:0];
    assign s_r_last_o = m_r_last_i;
    assign s_r_data_o = m_r_data_i;

    always_comb begin
        for (int i = 0; i < NUM_SLICES; i++)
            dec_ok[i] = r_dec[i] & (outst_q[i] != '0);
    end

    // Grant never happens at MAX_OUTST, so the increment cannot wrap.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < NUM_SLICES; i++) outst_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_SLICES; i++) begin
                if (gnt[i] && !dec_ok[i])
                    outst_q[i] <= outst_q[i] + CNT_W'(1);
                else if (!gnt[i] && dec_ok[i])
                    outst_q[i] <= outst_q[i] - CNT_W'(1);
            end
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < NUM_SLICES; i++)
            if (resetN && r_dec[i]) assert (outst_q[i] != '0);
    end

endmodule

// File: tb/tb_pref_ar_arbiter.sv
// Directed bench for pref_ar_arbiter; five slices so an unused 3-bit prefix exists.
module tb_pref_ar_arbiter;

    localparam int NS  = 5;
    localparam int TW  = 8;
    localparam int IDW = 11;
`ifdef PREF_AR_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic                   clk = 1'b0;
    logic                   resetN;
    logic [NS-1:0]          s_ar_valid, s_ar_ready, s_ar_pref;
    logic [NS-1:0][63:0]    s_ar_addr;
    logic [NS-1:0][7:0]     s_ar_len;
    logic [NS-1:0][TW-1:0]  s_ar_id;
    logic                   m_ar_valid, m_ar_ready;
    logic [63:0]            m_ar_addr;
    logic [7:0]             m_ar_len;
    logic [IDW-1:0]         m_ar_id;
    logic                   m_r_valid, m_r_ready, m_r_last;
    logic [IDW-1:0]         m_r_id;
    logic [63:0]            m_r_data;
    logic [NS-1:0]          s_r_valid, s_r_ready;
    logic [TW-1:0]          s_r_id;
    logic                   s_r_last;
    logic [63:0]            s_r_data;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pref_ar_arbiter #(
        .NUM_SLICES(NS), .ADDR_BITS(64), .BURST_LEN_WIDTH(8), .TID_WIDTH(TW),
        .DATA_WIDTH(64), .MAX_OUTST(2), .STARVE_LIMIT(16)
    ) dut (
        .clk(clk), .resetN(resetN),
        .s_ar_valid_i(s_ar_valid), .s_ar_ready_o(s_ar_ready), .s_ar_pref_i(s_ar_pref),
        .s_ar_addr_i(s_ar_addr), .s_ar_len_i(s_ar_len), .s_ar_id_i(s_ar_id),
        .m_ar_valid_o(m_ar_valid), .m_ar_ready_i(m_ar_ready), .m_ar_addr_o(m_ar_addr),
        .m_ar_len_o(m_ar_len), .m_ar_id_o(m_ar_id),
        .m_r_valid_i(m_r_valid), .m_r_ready_o(m_r_ready), .m_r_id_i(m_r_id),
        .m_r_last_i(m_r_last), .m_r_data_i(m_r_data),
        .s_r_valid_o(s_r_valid), .s_r_ready_i(s_r_ready), .s_r_id_o(s_r_id),
        .s_r_last_o(s_r_last), .s_r_data_o(s_r_data)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [NS-1:0] exp_rdy;
    logic          prev_g0;

    initial begin
        resetN = 1'b0;
        s_ar_valid = '0; s_ar_pref = '0; s_ar_addr = '0; s_ar_len = '0; s_ar_id = '0;
        m_ar_ready = 1'b0; m_r_valid = 1'b0; m_r_id = '0; m_r_last = 1'b0; m_r_data = '0;
        s_r_ready = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", m_ar_valid, 0);
        chk("rst_addr", m_ar_addr, 0);
        chk("rst_id", m_ar_id, 0);
        chk("rst_len", m_ar_len, 0);
        resetN = 1'b1;
        tick();

        // 1: two demand requests, rr_ptr=0
        s_ar_valid = 5'b00101; m_ar_ready = 1'b1;
        s_ar_addr[0] = 64'h1000; s_ar_len[0] = 8'd3; s_ar_id[0] = 8'h11;
        s_ar_addr[2] = 64'h2000; s_ar_len[2] = 8'd4; s_ar_id[2] = 8'h22;
        #1 chk("t1_rdy_first", s_ar_ready, 5'b00001);
        tick(); s_ar_valid = 5'b00100;
        #1 chk("t1_id0", m_ar_id, 11'h011);
        chk("t1_addr0", m_ar_addr, 64'h1000);
        chk("t1_len0", m_ar_len, 3);
        chk("t1_valid", m_ar_valid, 1);
        chk("t1_rdy_second", s_ar_ready, 5'b00100);
        tick(); s_ar_valid = '0;
        #1 chk("t1_id2", m_ar_id, 11'h222);
        chk("t1_addr2", m_ar_addr, 64'h2000);

        // 2: prefetch slice 1 vs demand slice 3
        s_ar_valid = 5'b01010; s_ar_pref = 5'b00010;
        s_ar_addr[1] = 64'h3000; s_ar_id[1] = 8'h33;
        s_ar_addr[3] = 64'h4000; s_ar_id[3] = 8'h44;
        #1 chk("t2_rdy_dem", s_ar_ready, 5'b01000);
        tick(); s_ar_valid = 5'b00010;
        #1 chk("t2_id3", m_ar_id, 11'h344);
        chk("t2_rdy_pref", s_ar_ready, 5'b00010);
        tick(); s_ar_valid = 5'b00100; s_ar_pref = '0; m_ar_ready = 1'b0;
        s_ar_addr[2] = 64'h5000; s_ar_id[2] = 8'h55;

        // 3: downstream backpressure for 5 cycles
        for (int k = 0; k < 5; k++) begin
            #1 chk("t3_hold_rdy", s_ar_ready, 0);
            chk("t3_hold_valid", m_ar_valid, 1);
            chk("t3_hold_id", m_ar_id, 11'h133);
            chk("t3_hold_addr", m_ar_addr, 64'h3000);
            tick();
        end
        m_ar_ready = 1'b1;
        #1 chk("t3_accept", s_ar_ready, 5'b00100);
        tick(); s_ar_valid = '0;
        #1 chk("t3_id2", m_ar_id, 11'h255);
        chk("t3_addr2", m_ar_addr, 64'h5000);

        // 5: R routing by prefix
        m_r_valid = 1'b1; m_r_id = 11'h25A; m_r_last = 1'b0; m_r_data = 64'hDEAD_BEEF_0123_4567;
        s_r_ready = '0;
        #1 chk("t5_rready_lo", m_r_ready, 0);
        chk("t5_svalid", s_r_valid, 5'b00100);
        chk("t5_sid", s_r_id, 8'h5A);
        chk("t5_sdata", s_r_data, 64'hDEAD_BEEF_0123_4567);
        tick(); s_r_ready = 5'b00100;
        #1 chk("t5_rready_hi", m_r_ready, 1);
        tick(); m_r_last = 1'b1;
        #1 chk("t5_slast", s_r_last, 1);
        tick(); m_r_id = 11'h777; s_r_ready = '0;
        #1 chk("t5_sink_ready", m_r_ready, 1);
        chk("t5_sink_svalid", s_r_valid, 0);
        tick(); m_r_id = 11'h0AB; s_r_ready = 5'b00001;
        #1 chk("t5_svalid0", s_r_valid, 5'b00001);
        chk("t5_sid0", s_r_id, 8'hAB);
        tick(); m_r_valid = 1'b0; s_r_ready = '0; m_r_last = 1'b0;

        // 4: outstanding limit of 2 on slice 0
        s_ar_valid = 5'b00001; s_ar_addr[0] = 64'h6000; s_ar_id[0] = 8'h60;
        #1 chk("t4_rdy_1", s_ar_ready, 5'b00001);
        tick(); s_ar_addr[0] = 64'h6100;
        #1 chk("t4_rdy_2", s_ar_ready, 5'b00001);
        chk("t4_addr_1", m_ar_addr, 64'h6000);
        tick(); s_ar_addr[0] = 64'h6200;
        #1 chk("t4_stall_a", s_ar_ready, 0);
        chk("t4_addr_2", m_ar_addr, 64'h6100);
        tick();
        #1 chk("t4_stall_b", s_ar_ready, 0);
        m_r_valid = 1'b1; m_r_id = 11'h0AB; m_r_last = 1'b1; s_r_ready = 5'b00001;
        #1 chk("t4_stall_c", s_ar_ready, 0);
        tick(); m_r_valid = 1'b0; s_r_ready = '0;
        #1 chk("t4_rdy_3", s_ar_ready, 5'b00001);
        tick(); s_ar_valid = '0;
        #1 chk("t4_addr_3", m_ar_addr, 64'h6200);
        m_r_valid = 1'b1; s_r_ready = 5'b00001;
        tick(); tick();
        m_r_valid = 1'b0; s_r_ready = '0;

        // 6: prefetch slice 1 vs continuous demand from slice 0
        s_ar_valid = 5'b00011; s_ar_pref = 5'b00010;
        s_ar_addr[0] = 64'h8000; s_ar_addr[1] = 64'h7000; s_ar_id[1] = 8'h77;
        prev_g0 = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            m_r_valid = prev_g0; m_r_id = 11'h0AB; m_r_last = 1'b1; s_r_ready = 5'b00001;
            exp_rdy = (GUARD && c == 17) ? 5'b00010 : 5'b00001;
            #1 chk($sformatf("t6_c%0d", c), s_ar_ready, exp_rdy);
            prev_g0 = exp_rdy[0];
            tick();
        end
        s_ar_valid = '0; s_ar_pref = '0; m_r_valid = 1'b0; s_r_ready = '0;

        // 7: async reset with an AR pending and a burst mid-flight
        m_ar_ready = 1'b0; m_r_valid = 1'b1; m_r_last = 1'b0; s_r_ready = 5'b00001;
        #2 resetN = 1'b0;
        #1 chk("t7_valid", m_ar_valid, 0);
        chk("t7_id", m_ar_id, 0);
        chk("t7_addr", m_ar_addr, 0);
        chk("t7_len", m_ar_len, 0);
        m_r_valid = 1'b0; s_r_ready = '0;
        tick(); resetN = 1'b1;
        tick();
        m_ar_ready = 1'b1; s_ar_valid = 5'b00011;
        #1 chk("t7_rr_reset", s_ar_ready, 5'b00001);
        tick(); s_ar_valid = 5'b00001;
        #1 chk("t7_cnt_reset", s_ar_ready, 5'b00001);
        tick(); s_ar_valid = '0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
